// File: rtl/leftpad_pkg.sv
// Types and width helpers shared by the leftpad / leftstrip character-stream blocks.
package leftpad_pkg;

    typedef enum logic [1:0] {
        ST_READ,
        ST_O_STR,
        ST_DONE
    } state_e;

    // Width of total-length and stream-position counters.
    function automatic int total_w(input int str_len_max);
        return $clog2(2 * str_len_max);
    endfunction

    // Wide enough to hold str_len_max exactly.
    function automatic int strlen_w(input int str_len_max);
        return $clog2(str_len_max + 1);
    endfunction

    function automatic int padlen_w(input int str_len_max);
        return $clog2(2 * str_len_max);
    endfunction

    // Buffer index width, kept at least one bit for a single-entry buffer.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/leftstrip_if.sv
// Character-stream interface: padded input stream in, recovered string out.
interface leftstrip_if #(
    parameter int CHAR_W = 8
);
    logic              in_en;
    logic [CHAR_W-1:0] cin;
    logic              out_en;
    logic [CHAR_W-1:0] cout;

    modport master (
        output in_en,
        output cin,
        input  out_en,
        input  cout
    );

    modport slave (
        input  in_en,
        input  cin,
        output out_en,
        output cout
    );
endinterface

// File: rtl/leftstrip_buf.sv
// Recovered-string storage: append-only write port, combinational read, full flag.
module leftstrip_buf
    import leftpad_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int CHAR_W = 8,
    localparam int AW     = addr_w(DEPTH),
    localparam int CW     = strlen_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_idx,
    output logic [CHAR_W-1:0] rd_data,
    output logic [CW-1:0]     count,
    output logic              full
);

    logic [CHAR_W-1:0] mem [DEPTH];
    logic [CW-1:0]     wr_ptr;

    assign full    = (wr_ptr == CW'(DEPTH));
    assign count   = wr_ptr;
    assign rd_data = mem[rd_idx];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (wr_en && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the write pointer alone decides
    // which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/leftstrip.sv
// Strips leading pad characters from a fixed-length stream and replays the rest,
// reporting pad count and recovered length.
module leftstrip
    import leftpad_pkg::*;
#(
    parameter  int STR_LEN_MAX = 8,
    parameter  int CHAR_W      = 8,
    localparam int TW          = total_w(STR_LEN_MAX),
    localparam int SW          = strlen_w(STR_LEN_MAX),
    localparam int PW          = padlen_w(STR_LEN_MAX),
    localparam int AW          = addr_w(STR_LEN_MAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TW-1:0]     total,
    input  logic [CHAR_W-1:0] cpad,
    leftstrip_if.slave        s,
    output logic [SW-1:0]     strlen_out,
    output logic [PW-1:0]     padlen_out,
    output logic              ovf,
    output logic              done
);

    state_e            state_q, state_d;
    logic [TW-1:0]     total_la;
    logic [CHAR_W-1:0] cpad_la;
    logic [TW-1:0]     rcv_cnt;
    logic [PW-1:0]     padlen_q;
    logic [SW-1:0]     rd_idx;
    logic              stripping;
    logic              ovf_q;

    logic              accept, discard, store, last;
    logic              buf_full;
    logic [SW-1:0]     buf_count;
    logic [CHAR_W-1:0] buf_rd;

    assign accept  = (state_q == ST_READ) && s.in_en && (total_la != '0);
    assign discard = accept && stripping && (s.cin == cpad_la);
    assign store   = accept && !discard;
    assign last    = accept && (TW'(rcv_cnt + 1'b1) == total_la);

    leftstrip_buf #(
        .DEPTH  (STR_LEN_MAX),
        .CHAR_W (CHAR_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (store),
        .wr_data (s.cin),
        .rd_idx  (rd_idx[AW-1:0]),
        .rd_data (buf_rd),
        .count   (buf_count),
        .full    (buf_full)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_READ;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_READ: begin
                if (total_la == '0) begin
                    state_d = ST_DONE;
                end else if (last) begin
                    state_d = (buf_count != '0 || store) ? ST_O_STR : ST_DONE;
                end
            end
            ST_O_STR: begin
                if (SW'(rd_idx + 1'b1) == buf_count) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_la  <= total;
            cpad_la   <= cpad;
            rcv_cnt   <= '0;
            padlen_q  <= '0;
            rd_idx    <= '0;
            stripping <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            if (accept)               rcv_cnt   <= rcv_cnt + 1'b1;
            if (discard)              padlen_q  <= padlen_q + 1'b1;
            if (store)                stripping <= 1'b0;
            // A store into a full buffer is the dropped-character case.
            if (store && buf_full)    ovf_q     <= 1'b1;
            if (state_q == ST_O_STR)  rd_idx    <= rd_idx + 1'b1;
        end
    end

    assign s.out_en   = (state_q == ST_O_STR);
    assign s.cout     = s.out_en ? buf_rd : '0;
    assign strlen_out = buf_count;
    assign padlen_out = padlen_q;
    assign ovf        = ovf_q;
    assign done       = (state_q == ST_DONE);

    a_out_en_state : assert property (@(posedge clk) disable iff (rst)
        s.out_en == (state_q == ST_O_STR));

    a_no_return_read : assert property (@(posedge clk) disable iff (rst)
        (state_q != ST_READ) |=> (state_q != ST_READ));

    a_done_counts : assert property (@(posedge clk) disable iff (rst)
        done |-> (int'(padlen_out) + int'(strlen_out) <= int'(total_la)));

endmodule

// File: tb/tb_leftstrip.sv
// Self-checking bench for leftstrip: directed table, hand-written corner sequences,
// and randomized streams against a string-level reference model.
module tb_leftstrip;

    localparam int BUDGET = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] total = '0;
    logic [7:0] cpad = '0;
    logic [3:0] strlen_out;
    logic [3:0] padlen_out;
    logic       ovf;
    logic       done;

    leftstrip_if #(.CHAR_W(8)) sif ();

    leftstrip #(.STR_LEN_MAX(8), .CHAR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .total      (total),
        .cpad       (cpad),
        .s          (sif),
        .strlen_out (strlen_out),
        .padlen_out (padlen_out),
        .ovf        (ovf),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus for one run: per-cycle in_en/cin, plus the cycle of each accept.
    bit  st_en[$];
    byte st_ch[$];
    int  acc_cyc[$];
    byte exp_q[$];

    // Observations of one run.
    byte o_chars[$];
    int  o_first, o_done, o_ovf_cyc, o_stray, o_gap, o_pad, o_str;
    bit  o_ovf;
    logic [7:0] c0_cout;
    logic c0_out_en, c0_done, c0_ovf;
    logic [3:0] c0_str, c0_pad;

    typedef struct {
        int    total;
        byte   cpad;
        string stream;
        string exp_out;
        int    pad;
        int    str;
        bit    ovf;
        int    done_cyc;
        int    ovf_cyc;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic do_reset(input int t, input byte p);
        @(posedge clk); #1;
        rst = 1'b1; total = 4'(t); cpad = p; sif.in_en = 1'b0; sif.cin = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic clear_stim();
        st_en.delete(); st_ch.delete(); acc_cyc.delete();
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            st_en.push_back(1'b0);
            st_ch.push_back(byte'($urandom_range(0, 255)));
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            acc_cyc.push_back(st_en.size());
            st_en.push_back(1'b1);
            st_ch.push_back(s[i]);
        end
    endtask

    task automatic set_exp(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Drives st_en/st_ch from cycle 0 (right after reset) until done or budget.
    task automatic run_stream();
        o_chars.delete();
        o_first = -1; o_done = -1; o_ovf_cyc = -1; o_stray = 0; o_gap = 0;
        for (int c = 0; c < BUDGET; c++) begin
            sif.in_en = (c < st_en.size()) ? st_en[c] : 1'b0;
            sif.cin   = (c < st_ch.size()) ? st_ch[c] : 8'h00;
            @(negedge clk);
            if (c == 0) begin
                c0_out_en = sif.out_en; c0_cout = sif.cout; c0_done = done;
                c0_str = strlen_out; c0_pad = padlen_out; c0_ovf = ovf;
            end
            if (sif.out_en) begin
                if (o_first < 0) o_first = c;
                else if (c != o_first + o_chars.size()) o_gap++;
                o_chars.push_back(sif.cout);
            end else if (sif.cout != 8'h00) begin
                o_stray++;
            end
            if (ovf && o_ovf_cyc < 0) o_ovf_cyc = c;
            o_pad = int'(padlen_out); o_str = int'(strlen_out); o_ovf = ovf;
            if (done) begin
                o_done = c;
                break;
            end
            @(posedge clk); #1;
        end
        sif.in_en = 1'b0;
    endtask

    task automatic check_run(input string name, input int pad, input int str, input bit ov,
                             input int done_cyc, input int ovf_cyc, input int first);
        check({name, ".done_cycle"}, o_done, done_cyc);
        check({name, ".padlen"}, o_pad, pad);
        check({name, ".strlen"}, o_str, str);
        check({name, ".ovf"}, o_ovf, ov);
        check({name, ".ovf_cycle"}, o_ovf_cyc, ovf_cyc);
        check({name, ".n_out"}, o_chars.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < o_chars.size(); i++)
            check($sformatf("%s.cout[%0d]", name, i), o_chars[i], exp_q[i]);
        check({name, ".first_out"}, o_first, first);
        check({name, ".out_gaps"}, o_gap, 0);
        check({name, ".cout_idle_nonzero"}, o_stray, 0);
    endtask

    task automatic check_c0(input string name);
        check({name, ".c0_out_en"}, c0_out_en, 0);
        check({name, ".c0_cout"}, c0_cout, 0);
        check({name, ".c0_done"}, c0_done, 0);
        check({name, ".c0_strlen"}, c0_str, 0);
        check({name, ".c0_padlen"}, c0_pad, 0);
        check({name, ".c0_ovf"}, c0_ovf, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.in_en = 1'b0;
        sif.cin   = '0;

        vecs[0] = '{5,  "!", "!!foo",      "foo",      2, 3, 1'b0, 8,  -1};
        vecs[1] = '{4,  "!", "!!!!",       "",         4, 0, 1'b0, 4,  -1};
        vecs[2] = '{10, "!", "abcdefghij", "abcdefgh", 0, 8, 1'b1, 18, 9};
        vecs[3] = '{3,  "!", "a!!",        "a!!",      0, 3, 1'b0, 6,  -1};
        vecs[4] = '{6,  " ", "  ab  ",     "ab  ",     2, 4, 1'b0, 10, -1};

        for (int v = 0; v < 5; v++) begin
            do_reset(vecs[v].total, vecs[v].cpad);
            clear_stim();
            push_str(vecs[v].stream);
            set_exp(vecs[v].exp_out);
            run_stream();
            check_run($sformatf("vec%0d", v), vecs[v].pad, vecs[v].str, vecs[v].ovf,
                      vecs[v].done_cyc, vecs[v].ovf_cyc,
                      (vecs[v].str > 0) ? vecs[v].stream.len() : -1);
            if (v == 0) check_c0("vec0");
        end

        // Empty stream: one cycle in read, then done.
        do_reset(0, "!");
        clear_stim();
        set_exp("");
        run_stream();
        check_c0("total0");
        check_run("total0", 0, 0, 1'b0, 1, -1, -1);

        // Input gaps stall reading; an interior pad is kept.
        do_reset(4, "!");
        clear_stim();
        push_str("!");
        push_idle(2);
        push_str("a!b");
        set_exp("a!b");
        run_stream();
        check_run("gaps", 1, 3, 1'b0, 9, -1, 6);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("gaps.done_held", done, 1);
        check("gaps.out_en_after_done", sif.out_en, 0);

        // Reset during the second output cycle aborts, then a new stream runs.
        do_reset(5, "!");
        clear_stim();
        push_str("!!foo");
        for (int c = 0; c < 6; c++) begin
            sif.in_en = (c < 5) ? 1'b1 : 1'b0;
            sif.cin   = (c < 5) ? st_ch[c] : 8'h00;
            @(posedge clk); #1;
        end
        sif.in_en = 1'b0;
        rst = 1'b1; total = 4'd2; cpad = "!";
        @(negedge clk);
        check("abort.out_en_before", sif.out_en, 1);
        check("abort.cout_before", sif.cout, "o");
        @(posedge clk); #1;
        rst = 1'b0;
        clear_stim();
        push_str("xy");
        set_exp("xy");
        run_stream();
        check_c0("abort");
        check_run("abort.xy", 0, 2, 1'b0, 4, -1, 2);

        // Randomized streams against a string-level model.
        for (int r = 0; r < 40; r++) begin
            int  t, npad, nsuf, nst, k, done_exp, ovf_exp;
            byte p, ch;
            byte model[$];
            t = $urandom_range(0, 15);
            p = byte'($urandom_range(33, 126));
            clear_stim();
            model.delete();
            for (int i = 0; i < t; i++) begin
                if ($urandom_range(0, 2) == 0) push_idle(1);
                ch = ($urandom_range(0, 1) == 1) ? p : byte'($urandom_range(97, 100));
                acc_cyc.push_back(st_en.size());
                st_en.push_back(1'b1);
                st_ch.push_back(ch);
                model.push_back(ch);
            end
            npad = 0;
            while (npad < t && model[npad] == p) npad++;
            nsuf = t - npad;
            nst  = (nsuf > 8) ? 8 : nsuf;
            exp_q.delete();
            for (int i = 0; i < nst; i++) exp_q.push_back(model[npad + i]);
            k        = (t > 0) ? acc_cyc[t - 1] : 0;
            done_exp = (t == 0) ? 1 : k + 1 + nst;
            ovf_exp  = (nsuf > 8) ? acc_cyc[npad + 8] + 1 : -1;
            do_reset(t, p);
            run_stream();
            check_run($sformatf("rand%0d", r), npad, nst, nsuf > 8, done_exp, ovf_exp,
                      (nst > 0) ? k + 1 : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/leftstrip.md
# leftstrip

Inverse of the leftpad block, placed on the receive side of the same character-stream interface. It accepts a padded character stream of known total length and discards every leading pad character. It buffers the remaining string and replays it one character per cycle with an output strobe. It also reports the stripped pad count and the recovered string length, so a consumer can reconstruct the original leftpad arguments.

## Interface
Parameters:
- STR_LEN_MAX, 8, maximum recovered (stored) string length
- CHAR_W, 8, character width in bits

Ports:
- clk  in  1  clock; all events on rising edge
- rst  in  1  reset, synchronous, active-high; also latches `total` and `cpad`
- total  in  $clog2(2*STR_LEN_MAX)  total incoming stream length; sampled only while rst=1
- cpad  in  CHAR_W  pad character to strip; sampled only while rst=1
- in_en  in  1  cin valid this cycle; ignored outside ST_READ
- cin  in  CHAR_W  incoming character
- cout  out  CHAR_W  recovered string character; 0 when out_en=0
- out_en  out  1  cout valid this cycle
- strlen_out  out  $clog2(STR_LEN_MAX+1)  stored string length
- padlen_out  out  $clog2(2*STR_LEN_MAX)  number of stripped leading pad characters
- ovf  out  1  sticky; a non-pad suffix longer than STR_LEN_MAX was received
- done  out  1  operation complete; held until next rst

## Operation
- Reset cycle:
  - latch total_la and cpad_la
  - state←ST_READ
  - counters and flags cleared
  - outputs: out_en=0, cout=0, done=0, ovf=0, strlen_out=0, padlen_out=0
- ST_READ: each cycle with in_en=1 accepts one character and increments rcv_cnt.
  - While `stripping` is set and cin==cpad_la: discard the character; padlen_out++.
  - The first cin!=cpad_la clears `stripping`. That character and every later character, including later pad characters, are written to buf[strlen_out]; strlen_out++.
  - If strlen_out==STR_LEN_MAX, the character is dropped and ovf←1. Counting continues; strlen_out saturates.
  - When an accept makes rcv_cnt+1==total_la: go to ST_O_STR if the stored count is >0, else ST_DONE.
  - total_la==0: go to ST_DONE after exactly one cycle in ST_READ, regardless of in_en.
- ST_O_STR: out_en=1 and cout=buf[rd_idx]; rd_idx++ each cycle. After rd_idx+1==strlen_out, go to ST_DONE.
- ST_DONE: done=1, out_en=0. Terminal until rst.
- Stripping is greedy. A string whose own first characters equal cpad is indistinguishable from padding; this is inherent to the protocol and is accepted.
- rst has priority in any state. A reset mid-read or mid-output aborts immediately with the reset values above; buffer contents need not be cleared.
- Arithmetic:
  - rcv_cnt and padlen_out are $clog2(2*STR_LEN_MAX) bits and never exceed total_la, so they never wrap.
  - strlen_out is wide enough to hold STR_LEN_MAX exactly.
  - Invariant at done: padlen_out + (characters stored or dropped) == total_la.

## Timing
- Reset cycle = cycle −1. The first character can be accepted in cycle 0.
- Let cycle k be the one accepting the last character:
  - out_en goes high in cycle k+1 and stays high for exactly strlen_out consecutive cycles.
  - cout in cycle k+1+i is the i-th stored character.
  - done rises in cycle k+1+strlen_out. If nothing was stored, it rises in k+1.
- strlen_out and padlen_out update the cycle after each accept and are final from cycle k+1.
- ovf asserts the cycle after the first dropped character.
- Gaps in in_en stall ST_READ with no state change. There is no backpressure on output.

## Structure
- Shared package leftpad_pkg holds:
  - state enum {ST_READ, ST_O_STR, ST_DONE}
  - width localparams/functions for the total, strlen and padlen widths, shared with leftpad
- Sub-module leftstrip_buf holds the STR_LEN_MAX×CHAR_W storage: write port with write pointer, combinational read at rd_idx, full flag.
- The top level holds the FSM, strip logic and counters.
- Add SVA alongside the RTL:
  - out_en iff state==ST_O_STR
  - no return to ST_READ
  - done implies padlen_out+strlen_out ≤ total_la

## Test plan
- total=5, cpad="!", stream "!!foo" back-to-back → cycles 5–7 out "f","o","o"; padlen_out=2, strlen_out=3; done in cycle 8.
- total=4, stream "!!!!" → out_en never high; padlen_out=4, strlen_out=0; done in cycle 4.
- total=0 → out_en never high; done in cycle 1; all counts 0.
- total=4, "!" then 2 idle cycles, then "a!b" → out "a","!","b" (interior pad kept); padlen_out=1, strlen_out=3.
- STR_LEN_MAX=8, total=10, "abcdefghij" → out "a".."h"; strlen_out=8; ovf=1 from the cycle after "i" is accepted.
- Stream "!!foo", rst asserted during 2nd output cycle → next cycle out_en=0, done=0, counts 0; new stream "xy" (total=2) → out "x","y".
